// File: rtl/reg_read_arbiter.sv
// Round-robin arbiter that lets the RS (two operands) and the LSB (one operand) share the
// register file's registered read-port pair. Two-stage pipeline with commit-write forwarding.
module reg_read_arbiter #(
  parameter int XLEN    = 32,
  parameter int REG_AW  = 5,
  parameter int RR_INIT = 0
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              flush_in,
  input  logic              rs_req,
  input  logic [REG_AW-1:0] rs_rs1,
  input  logic [REG_AW-1:0] rs_rs2,
  output logic              rs_gnt,
  output logic              rs_rsp_valid,
  output logic [XLEN-1:0]   rs_rsp_rs1,
  output logic [XLEN-1:0]   rs_rsp_rs2,
  input  logic              lsb_req,
  input  logic [REG_AW-1:0] lsb_rs1,
  output logic              lsb_gnt,
  output logic              lsb_rsp_valid,
  output logic [XLEN-1:0]   lsb_rsp_rs1,
  output logic              rf_rd_en,
  output logic [REG_AW-1:0] rf_raddr1,
  output logic [REG_AW-1:0] rf_raddr2,
  input  logic [XLEN-1:0]   rf_rdata1,
  input  logic [XLEN-1:0]   rf_rdata2,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_data
);

  // last_q = 1 means the LSB was granted most recently
  logic              last_q, last_d;
  logic              s1_vld_q, s1_vld_d, s1_own_q, s1_own_d;
  logic [REG_AW-1:0] s1_a1_q, s1_a1_d, s1_a2_q, s1_a2_d;
  logic              s1_f1v_q, s1_f1v_d, s1_f2v_q, s1_f2v_d;
  logic [XLEN-1:0]   s1_f1d_q, s1_f1d_d, s1_f2d_q, s1_f2d_d;
  logic              s2_vld_q, s2_vld_d, s2_own_q, s2_own_d;
  logic [XLEN-1:0]   rs_rsp1_q, rs_rsp1_d, rs_rsp2_q, rs_rsp2_d;
  logic [XLEN-1:0]   lsb_rsp_q, lsb_rsp_d;
  logic [XLEN-1:0]   op1, op2;
  logic              gate;

  // Priority: x0 is always zero, then this cycle's commit, then the commit seen at grant, then RF.
  function automatic logic [XLEN-1:0] resolve(
    input logic [REG_AW-1:0] a, input logic fv, input logic [XLEN-1:0] fd,
    input logic [XLEN-1:0] rd, input logic we, input logic [REG_AW-1:0] wa,
    input logic [XLEN-1:0] wd);
    if (a == '0)            return '0;
    if (we && (wa == a))    return wd;
    if (fv)                 return fd;
    return rd;
  endfunction

  always_comb begin
    gate    = rdy_in & ~flush_in & rst_in;
    rs_gnt  = 1'b0;
    lsb_gnt = 1'b0;
    if (gate) begin
      if (rs_req && lsb_req) begin
        rs_gnt  = last_q;
        lsb_gnt = ~last_q;
      end else begin
        rs_gnt  = rs_req;
        lsb_gnt = lsb_req;
      end
    end
    rf_rd_en  = rs_gnt | lsb_gnt;
    rf_raddr1 = rs_gnt ? rs_rs1 : (lsb_gnt ? lsb_rs1 : '0);
    rf_raddr2 = rs_gnt ? rs_rs2 : '0;
    last_d    = lsb_gnt ? 1'b1 : (rs_gnt ? 1'b0 : last_q);
  end

  always_comb begin
    op1 = resolve(s1_a1_q, s1_f1v_q, s1_f1d_q, rf_rdata1, wb_en, wb_rd, wb_data);
    op2 = resolve(s1_a2_q, s1_f2v_q, s1_f2d_q, rf_rdata2, wb_en, wb_rd, wb_data);
  end

  always_comb begin
    s1_vld_d  = s1_vld_q;
    s1_own_d  = s1_own_q;
    s1_a1_d   = s1_a1_q;
    s1_a2_d   = s1_a2_q;
    s1_f1v_d  = s1_f1v_q;
    s1_f1d_d  = s1_f1d_q;
    s1_f2v_d  = s1_f2v_q;
    s1_f2d_d  = s1_f2d_q;
    s2_vld_d  = s2_vld_q;
    s2_own_d  = s2_own_q;
    rs_rsp1_d = rs_rsp1_q;
    rs_rsp2_d = rs_rsp2_q;
    lsb_rsp_d = lsb_rsp_q;
    if (flush_in) begin
      s1_vld_d = 1'b0;
      s2_vld_d = 1'b0;
    end else if (rdy_in) begin
      s1_vld_d = rf_rd_en;
      s1_own_d = lsb_gnt;
      s1_a1_d  = rf_raddr1;
      s1_a2_d  = rf_raddr2;
      s1_f1v_d = wb_en && (wb_rd == rf_raddr1) && (rf_raddr1 != '0);
      s1_f2v_d = wb_en && (wb_rd == rf_raddr2) && (rf_raddr2 != '0);
      s1_f1d_d = wb_data;
      s1_f2d_d = wb_data;
      s2_vld_d = s1_vld_q;
      s2_own_d = s1_own_q;
      if (s1_vld_q) begin
        if (s1_own_q) begin
          lsb_rsp_d = op1;
        end else begin
          rs_rsp1_d = op1;
          rs_rsp2_d = op2;
        end
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      last_q    <= (RR_INIT != 0);
      s1_vld_q  <= 1'b0;
      s1_own_q  <= 1'b0;
      s1_a1_q   <= '0;
      s1_a2_q   <= '0;
      s1_f1v_q  <= 1'b0;
      s1_f1d_q  <= '0;
      s1_f2v_q  <= 1'b0;
      s1_f2d_q  <= '0;
      s2_vld_q  <= 1'b0;
      s2_own_q  <= 1'b0;
      rs_rsp1_q <= '0;
      rs_rsp2_q <= '0;
      lsb_rsp_q <= '0;
    end else begin
      last_q    <= last_d;
      s1_vld_q  <= s1_vld_d;
      s1_own_q  <= s1_own_d;
      s1_a1_q   <= s1_a1_d;
      s1_a2_q   <= s1_a2_d;
      s1_f1v_q  <= s1_f1v_d;
      s1_f1d_q  <= s1_f1d_d;
      s1_f2v_q  <= s1_f2v_d;
      s1_f2d_q  <= s1_f2d_d;
      s2_vld_q  <= s2_vld_d;
      s2_own_q  <= s2_own_d;
      rs_rsp1_q <= rs_rsp1_d;
      rs_rsp2_q <= rs_rsp2_d;
      lsb_rsp_q <= lsb_rsp_d;
    end
  end

  // A stalled response stays in S2 and pulses once rdy_in returns
  assign rs_rsp_valid  = s2_vld_q & ~s2_own_q & rdy_in;
  assign lsb_rsp_valid = s2_vld_q & s2_own_q & rdy_in;
  assign rs_rsp_rs1    = rs_rsp1_q;
  assign rs_rsp_rs2    = rs_rsp2_q;
  assign lsb_rsp_rs1   = lsb_rsp_q;

endmodule
